// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline types: opcodes, ALU ops, immediate formats
// and the ID/EX pipeline register bundle.
package riscv_pkg;

    localparam int XLEN = 32;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_PASS_B
    } alu_ctrl_e;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_write;
        logic            mem_read;
        logic            branch;
        logic            jump;
        logic            jalr;
        logic            alu_src_a_pc;
        logic            alu_src_b_imm;
        logic [1:0]      result_src;
        alu_ctrl_e       alu_ctrl;
        logic [2:0]      funct3;
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc_plus4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            illegal;
    } idex_t;

    // alt selects SUB for funct3=0 and SRA for funct3=5
    function automatic alu_ctrl_e alu_from_f3(input logic [2:0] f3,
                                              input logic alt);
        alu_ctrl_e op;
        case (f3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate formatter: gathers the format's bits from the
// instruction word and sign-extends from instr[31].
module imm_gen #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic                [31:0]     instr_i,
    input  riscv_pkg::imm_fmt_e            fmt_i,
    output logic                [XLEN-1:0] imm_o
);
    import riscv_pkg::*;

    logic [31:0] imm32;

    // Bit gather per format; I-format is the fallback
    always_comb begin
        imm32 = {{21{instr_i[31]}}, instr_i[30:20]};
        case (fmt_i)
            IMM_S: imm32 = {{21{instr_i[31]}}, instr_i[30:25],
                            instr_i[11:7]};
            IMM_B: imm32 = {{20{instr_i[31]}}, instr_i[7],
                            instr_i[30:25], instr_i[11:8], 1'b0};
            IMM_U: imm32 = {instr_i[31:12], 12'b0};
            IMM_J: imm32 = {{12{instr_i[31]}}, instr_i[19:12],
                            instr_i[20], instr_i[30:21], 1'b0};
            default: ;
        endcase
    end

    assign imm_o = {{(XLEN-31){imm32[31]}}, imm32[30:0]};

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with ID/EX register, load-use hazard
// detection and bubble insertion on stall, flush and reset.
module id_stage #(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 d_valid,
    input  logic [31:0]          d_instr,
    input  logic [XLEN-1:0]      d_pc,
    input  logic [XLEN-1:0]      d_pc_plus4,
    output logic [4:0]           rf_a1,
    output logic [4:0]           rf_a2,
    input  logic [XLEN-1:0]      rf_rd1,
    input  logic [XLEN-1:0]      rf_rd2,
    input  logic                 flush_e,
    output logic                 stall_d,
    output logic                 e_valid,
    output logic                 e_reg_write,
    output logic                 e_mem_write,
    output logic                 e_mem_read,
    output logic                 e_branch,
    output logic                 e_jump,
    output logic                 e_jalr,
    output logic                 e_alu_src_a_pc,
    output logic                 e_alu_src_b_imm,
    output logic [1:0]           e_result_src,
    output riscv_pkg::alu_ctrl_e e_alu_ctrl,
    output logic [2:0]           e_funct3,
    output logic [XLEN-1:0]      e_rd1,
    output logic [XLEN-1:0]      e_rd2,
    output logic [XLEN-1:0]      e_imm,
    output logic [XLEN-1:0]      e_pc,
    output logic [XLEN-1:0]      e_pc_plus4,
    output logic [4:0]           e_rs1,
    output logic [4:0]           e_rs2,
    output logic [4:0]           e_rd,
    output logic                 e_illegal
);
    import riscv_pkg::*;

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1_f;
    logic [4:0] rs2_f;
    logic [4:0] rd_f;

    assign opcode = d_instr[6:0];
    assign rd_f   = d_instr[11:7];
    assign f3     = d_instr[14:12];
    assign rs1_f  = d_instr[19:15];
    assign rs2_f  = d_instr[24:20];
    assign f7     = d_instr[31:25];

    assign rf_a1 = rs1_f;
    assign rf_a2 = rs2_f;

    logic      reg_write, mem_write, mem_read;
    logic      branch, jump, jalr;
    logic      src_a_pc, src_b_imm;
    logic      illegal, use_rs1, use_rs2;
    logic [1:0] result_src;
    alu_ctrl_e alu_ctrl;
    imm_fmt_e  imm_fmt;
    logic [XLEN-1:0] imm;

    idex_t e_d, e_q;
    logic  hazard;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr_i (d_instr),
        .fmt_i   (imm_fmt),
        .imm_o   (imm)
    );

    // Control decode; illegal encodings drop every side effect
    always_comb begin
        reg_write  = 1'b0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        branch     = 1'b0;
        jump       = 1'b0;
        jalr       = 1'b0;
        src_a_pc   = 1'b0;
        src_b_imm  = 1'b0;
        result_src = RES_ALU;
        alu_ctrl   = ALU_ADD;
        imm_fmt    = IMM_I;
        illegal    = 1'b0;
        use_rs1    = 1'b1;
        use_rs2    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                reg_write = 1'b1;
                src_b_imm = 1'b1;
                alu_ctrl  = ALU_PASS_B;
                imm_fmt   = IMM_U;
                use_rs1   = 1'b0;
            end
            OPC_AUIPC: begin
                reg_write = 1'b1;
                src_a_pc  = 1'b1;
                src_b_imm = 1'b1;
                imm_fmt   = IMM_U;
                use_rs1   = 1'b0;
            end
            OPC_JAL: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                src_a_pc   = 1'b1;
                src_b_imm  = 1'b1;
                result_src = RES_PC4;
                imm_fmt    = IMM_J;
                use_rs1    = 1'b0;
            end
            OPC_JALR: begin
                reg_write  = 1'b1;
                jump       = 1'b1;
                jalr       = 1'b1;
                src_b_imm  = 1'b1;
                result_src = RES_PC4;
                illegal    = (f3 != 3'd0);
            end
            OPC_BRANCH: begin
                branch   = 1'b1;
                alu_ctrl = ALU_SUB;
                imm_fmt  = IMM_B;
                use_rs2  = 1'b1;
                illegal  = (f3 == 3'd2) || (f3 == 3'd3);
            end
            OPC_LOAD: begin
                reg_write  = 1'b1;
                mem_read   = 1'b1;
                src_b_imm  = 1'b1;
                result_src = RES_MEM;
                illegal    = (f3 == 3'd3) || (f3 == 3'd6) ||
                             (f3 == 3'd7);
            end
            OPC_STORE: begin
                mem_write = 1'b1;
                src_b_imm = 1'b1;
                imm_fmt   = IMM_S;
                use_rs2   = 1'b1;
                illegal   = (f3 > 3'd2);
            end
            OPC_OPIMM: begin
                reg_write = 1'b1;
                src_b_imm = 1'b1;
                alu_ctrl  = alu_from_f3(f3, (f3 == 3'd5) && f7[5]);
                illegal   = ((f3 == 3'd1) && (f7 != 7'h00)) ||
                            ((f3 == 3'd5) && (f7 != 7'h00) &&
                             (f7 != 7'h20));
            end
            OPC_OP: begin
                reg_write = 1'b1;
                use_rs2   = 1'b1;
                alu_ctrl  = alu_from_f3(f3, f7[5]);
                illegal   = !((f7 == 7'h00) ||
                              ((f7 == 7'h20) &&
                               ((f3 == 3'd0) || (f3 == 3'd5))));
            end
            OPC_FENCE: ;
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            reg_write = 1'b0;
            mem_write = 1'b0;
            mem_read  = 1'b0;
            branch    = 1'b0;
            jump      = 1'b0;
            jalr      = 1'b0;
        end
    end

    // Load in EX whose rd feeds a source actually read in D
    assign hazard = e_q.valid && e_q.mem_read && (e_q.rd != 5'd0) &&
                    d_valid &&
                    ((use_rs1 && (rs1_f == e_q.rd)) ||
                     (use_rs2 && (rs2_f == e_q.rd)));
    assign stall_d = hazard && !flush_e;

    // Next ID/EX contents; unused source indices and non-writing rd are zeroed
    always_comb begin
        e_d               = '0;
        e_d.valid         = 1'b1;
        e_d.reg_write     = reg_write;
        e_d.mem_write     = mem_write;
        e_d.mem_read      = mem_read;
        e_d.branch        = branch;
        e_d.jump          = jump;
        e_d.jalr          = jalr;
        e_d.alu_src_a_pc  = src_a_pc;
        e_d.alu_src_b_imm = src_b_imm;
        e_d.result_src    = result_src;
        e_d.alu_ctrl      = alu_ctrl;
        e_d.funct3        = f3;
        e_d.rd1           = rf_rd1;
        e_d.rd2           = rf_rd2;
        e_d.imm           = imm;
        e_d.pc            = d_pc;
        e_d.pc_plus4      = d_pc_plus4;
        e_d.rs1           = use_rs1 ? rs1_f : 5'd0;
        e_d.rs2           = use_rs2 ? rs2_f : 5'd0;
        e_d.rd            = reg_write ? rd_f : 5'd0;
        e_d.illegal       = illegal;
    end

    // ID/EX register: reset, flush, stall and empty slots load a bubble
    always_ff @(posedge clk) begin
        if (reset || flush_e || stall_d || !d_valid) begin
            e_q <= '0;
        end else begin
            e_q <= e_d;
        end
    end

    assign e_valid         = e_q.valid;
    assign e_reg_write     = e_q.reg_write;
    assign e_mem_write     = e_q.mem_write;
    assign e_mem_read      = e_q.mem_read;
    assign e_branch        = e_q.branch;
    assign e_jump          = e_q.jump;
    assign e_jalr          = e_q.jalr;
    assign e_alu_src_a_pc  = e_q.alu_src_a_pc;
    assign e_alu_src_b_imm = e_q.alu_src_b_imm;
    assign e_result_src    = e_q.result_src;
    assign e_alu_ctrl      = e_q.alu_ctrl;
    assign e_funct3        = e_q.funct3;
    assign e_rd1           = e_q.rd1;
    assign e_rd2           = e_q.rd2;
    assign e_imm           = e_q.imm;
    assign e_pc            = e_q.pc;
    assign e_pc_plus4      = e_q.pc_plus4;
    assign e_rs1           = e_q.rs1;
    assign e_rs2           = e_q.rs2;
    assign e_rd            = e_q.rd;
    assign e_illegal       = e_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed cases then random instruction stream
// checked against an instruction-level reference model.
module tb_id_stage;
    import riscv_pkg::*;

    logic        clk;
    logic        reset;
    logic        d_valid;
    logic [31:0] d_instr, d_pc, d_pc_plus4;
    logic [4:0]  rf_a1, rf_a2;
    logic [31:0] rf_rd1, rf_rd2;
    logic        flush_e, stall_d;
    logic        e_valid, e_reg_write, e_mem_write, e_mem_read;
    logic        e_branch, e_jump, e_jalr;
    logic        e_alu_src_a_pc, e_alu_src_b_imm;
    logic [1:0]  e_result_src;
    alu_ctrl_e   e_alu_ctrl;
    logic [2:0]  e_funct3;
    logic [31:0] e_rd1, e_rd2, e_imm, e_pc, e_pc_plus4;
    logic [4:0]  e_rs1, e_rs2, e_rd;
    logic        e_illegal;

    id_stage #(.XLEN(32)) dut (
        .clk(clk), .reset(reset),
        .d_valid(d_valid), .d_instr(d_instr),
        .d_pc(d_pc), .d_pc_plus4(d_pc_plus4),
        .rf_a1(rf_a1), .rf_a2(rf_a2),
        .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
        .flush_e(flush_e), .stall_d(stall_d),
        .e_valid(e_valid), .e_reg_write(e_reg_write),
        .e_mem_write(e_mem_write), .e_mem_read(e_mem_read),
        .e_branch(e_branch), .e_jump(e_jump), .e_jalr(e_jalr),
        .e_alu_src_a_pc(e_alu_src_a_pc),
        .e_alu_src_b_imm(e_alu_src_b_imm),
        .e_result_src(e_result_src), .e_alu_ctrl(e_alu_ctrl),
        .e_funct3(e_funct3),
        .e_rd1(e_rd1), .e_rd2(e_rd2), .e_imm(e_imm),
        .e_pc(e_pc), .e_pc_plus4(e_pc_plus4),
        .e_rs1(e_rs1), .e_rs2(e_rs2), .e_rd(e_rd),
        .e_illegal(e_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        v, rw, mw, mr, br, jp, jr, ill;
        logic        use1, use2, chk_imm, chk_alu, chk_bimm, bimm;
        logic [1:0]  res;
        alu_ctrl_e   alu;
        logic [2:0]  f3;
        logic [31:0] imm, pc, pc4, rd1, rd2;
        logic [4:0]  rd, rs1, rs2;
    } exp_t;

    int          n_assert = 0;
    int          n_fail = 0;
    exp_t        m;
    logic        obs_stall, m_stall;
    logic [31:0] pc_cnt;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference decode straight from the RV32I instruction rules
    function automatic exp_t ref_decode(input logic [31:0] ins);
        exp_t x;
        logic [6:0] op, f7;
        logic [2:0] f3;
        logic signed [31:0] s;
        alu_ctrl_e tbl [8];
        tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU,
                ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
        x = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        s = ins;
        x.use1 = 1'b1;
        x.f3 = f3;
        case (op)
            7'h37: begin
                x.rw = 1; x.use1 = 0; x.chk_imm = 1;
                x.imm = ins & 32'hFFFFF000;
                x.alu = ALU_PASS_B; x.chk_alu = 1;
                x.bimm = 1; x.chk_bimm = 1;
            end
            7'h17: begin
                x.rw = 1; x.use1 = 0; x.chk_imm = 1;
                x.imm = ins & 32'hFFFFF000;
            end
            7'h6F: begin
                x.rw = 1; x.jp = 1; x.use1 = 0; x.res = 2;
                x.chk_imm = 1;
                x.imm = 32'((s >>> 31) <<< 20) |
                        (32'(ins[19:12]) << 12) |
                        (32'(ins[20]) << 11) |
                        (32'(ins[30:21]) << 1);
            end
            7'h67: begin
                x.rw = 1; x.jp = 1; x.jr = 1; x.res = 2;
                x.chk_imm = 1; x.imm = 32'(s >>> 20);
                x.ill = (f3 != 0);
            end
            7'h63: begin
                x.br = 1; x.use2 = 1; x.chk_imm = 1;
                x.imm = 32'((s >>> 31) <<< 12) |
                        (32'(ins[7]) << 11) |
                        (32'(ins[30:25]) << 5) |
                        (32'(ins[11:8]) << 1);
                x.ill = (f3 == 2) || (f3 == 3);
            end
            7'h03: begin
                x.rw = 1; x.mr = 1; x.res = 1;
                x.chk_imm = 1; x.imm = 32'(s >>> 20);
                x.alu = ALU_ADD; x.chk_alu = 1;
                x.bimm = 1; x.chk_bimm = 1;
                x.ill = !(f3 == 0 || f3 == 1 || f3 == 2 ||
                          f3 == 4 || f3 == 5);
            end
            7'h23: begin
                x.mw = 1; x.use2 = 1; x.chk_imm = 1;
                x.imm = 32'((s >>> 25) <<< 5) | 32'(ins[11:7]);
                x.alu = ALU_ADD; x.chk_alu = 1;
                x.bimm = 1; x.chk_bimm = 1;
                x.ill = (f3 > 2);
            end
            7'h13: begin
                x.rw = 1; x.chk_imm = 1; x.imm = 32'(s >>> 20);
                x.bimm = 1; x.chk_bimm = 1; x.chk_alu = 1;
                x.alu = tbl[f3];
                if (f3 == 5 && f7 == 7'h20) x.alu = ALU_SRA;
                x.ill = (f3 == 1 && f7 != 0) ||
                        (f3 == 5 && f7 != 0 && f7 != 7'h20);
            end
            7'h33: begin
                x.rw = 1; x.use2 = 1; x.chk_bimm = 1;
                x.chk_alu = 1; x.alu = tbl[f3];
                if (f7 == 7'h20 && f3 == 0) x.alu = ALU_SUB;
                if (f7 == 7'h20 && f3 == 5) x.alu = ALU_SRA;
                x.ill = !(f7 == 0 ||
                          (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
            end
            7'h0F: ;
            default: x.ill = 1;
        endcase
        if (x.ill) begin
            x.rw = 0; x.mw = 0; x.mr = 0;
            x.chk_imm = 0; x.chk_alu = 0; x.chk_bimm = 0;
        end
        x.rs1 = x.use1 ? ins[19:15] : 5'd0;
        x.rs2 = x.use2 ? ins[24:20] : 5'd0;
        x.rd  = ins[11:7];
        return x;
    endfunction

    function automatic logic [31:0] gen_instr();
        logic [6:0]  ops [12];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                7'h23, 7'h13, 7'h33, 7'h0F, 7'h03, 7'h7F};
        w = $urandom;
        w[6:0]   = ops[$urandom_range(0, 11)];
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 3))
            0: w[31:25] = 7'h00;
            1: w[31:25] = 7'h20;
            default: ;
        endcase
        return w;
    endfunction

    task automatic check_e();
        if (!m.v) begin
            chk("bub_valid", 32'(e_valid), 0);
            chk("bub_rw", 32'(e_reg_write), 0);
            chk("bub_mw", 32'(e_mem_write), 0);
            chk("bub_mr", 32'(e_mem_read), 0);
            chk("bub_br", 32'(e_branch), 0);
            chk("bub_jp", 32'(e_jump), 0);
            chk("bub_ill", 32'(e_illegal), 0);
            chk("bub_rd", 32'(e_rd), 0);
            chk("bub_rs1", 32'(e_rs1), 0);
            chk("bub_rs2", 32'(e_rs2), 0);
        end else begin
            chk("valid", 32'(e_valid), 1);
            chk("reg_write", 32'(e_reg_write), 32'(m.rw));
            chk("mem_write", 32'(e_mem_write), 32'(m.mw));
            chk("mem_read", 32'(e_mem_read), 32'(m.mr));
            chk("illegal", 32'(e_illegal), 32'(m.ill));
            chk("rs1", 32'(e_rs1), 32'(m.rs1));
            chk("rs2", 32'(e_rs2), 32'(m.rs2));
            chk("funct3", 32'(e_funct3), 32'(m.f3));
            chk("rd1", e_rd1, m.rd1);
            chk("rd2", e_rd2, m.rd2);
            chk("pc", e_pc, m.pc);
            chk("pc4", e_pc_plus4, m.pc4);
            if (m.rw) chk("rd", 32'(e_rd), 32'(m.rd));
            if (m.chk_imm) chk("imm", e_imm, m.imm);
            if (m.chk_alu) chk("alu", 32'(e_alu_ctrl), 32'(m.alu));
            if (m.chk_bimm)
                chk("b_imm", 32'(e_alu_src_b_imm), 32'(m.bimm));
            if (!m.ill) begin
                chk("branch", 32'(e_branch), 32'(m.br));
                chk("jump", 32'(e_jump), 32'(m.jp));
                chk("jalr", 32'(e_jalr), 32'(m.jr));
                chk("res_src", 32'(e_result_src), 32'(m.res));
            end
        end
    endtask

    // One clock: drive at negedge, check stall, advance model, check ID/EX
    task automatic cyc(input logic r, input logic f, input logic v,
                       input logic [31:0] ins);
        exp_t x;
        logic hz;
        reset = r;
        flush_e = f;
        d_valid = v;
        d_instr = ins;
        d_pc = pc_cnt;
        d_pc_plus4 = pc_cnt + 32'd4;
        rf_rd1 = $urandom;
        rf_rd2 = $urandom;
        #1;
        x = ref_decode(ins);
        hz = m.v && m.mr && (m.rd != 0) && v &&
             ((x.use1 && ins[19:15] == m.rd) ||
              (x.use2 && ins[24:20] == m.rd));
        m_stall = hz && !f;
        obs_stall = stall_d;
        chk("stall_d", 32'(stall_d), 32'(m_stall));
        chk("rf_a1", 32'(rf_a1), 32'(ins[19:15]));
        chk("rf_a2", 32'(rf_a2), 32'(ins[24:20]));
        if (r || f || m_stall || !v) begin
            m = '0;
        end else begin
            m = x;
            m.v = 1'b1;
            if (!m.rw) m.rd = 5'd0;
            m.pc = pc_cnt;
            m.pc4 = pc_cnt + 32'd4;
            m.rd1 = rf_rd1;
            m.rd2 = rf_rd2;
        end
        @(posedge clk);
        #1;
        check_e();
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] cur;
        logic r, f, v;
        m = '0;
        m_stall = 0;
        pc_cnt = 32'h100;
        reset = 1; flush_e = 0; d_valid = 1;
        d_instr = 32'h00500093;
        d_pc = 0; d_pc_plus4 = 4; rf_rd1 = 0; rf_rd2 = 0;
        @(posedge clk);
        @(negedge clk);

        cyc(1, 0, 1, 32'h00500093);
        chk("rst_imm", e_imm, 0);
        chk("rst_pc", e_pc, 0);
        chk("rst_alu", 32'(e_alu_ctrl), 0);
        chk("rst_res", 32'(e_result_src), 0);

        cyc(0, 0, 1, 32'h00500093);
        chk("addi_imm", e_imm, 5);
        chk("addi_rd", 32'(e_rd), 1);
        chk("addi_rw", 32'(e_reg_write), 1);
        chk("addi_bimm", 32'(e_alu_src_b_imm), 1);
        chk("addi_alu", 32'(e_alu_ctrl), 32'(ALU_ADD));

        pc_cnt += 4;
        cyc(0, 0, 1, 32'h0000A103);
        pc_cnt += 4;
        cyc(0, 0, 1, 32'h001101B3);
        chk("lu_stall", 32'(obs_stall), 1);
        chk("lu_bubble", 32'(e_valid), 0);
        cyc(0, 0, 1, 32'h001101B3);
        chk("lu_nostall", 32'(obs_stall), 0);
        chk("lu_rs1", 32'(e_rs1), 2);
        chk("lu_rs2", 32'(e_rs2), 1);

        pc_cnt += 4;
        cyc(0, 0, 1, 32'h0002A283);
        pc_cnt += 4;
        cyc(0, 0, 1, 32'h123452B7);
        chk("lui_stall", 32'(obs_stall), 0);
        chk("lui_imm", e_imm, 32'h12345000);
        chk("lui_rs1", 32'(e_rs1), 0);

        pc_cnt += 4;
        cyc(0, 0, 1, 32'hFE000CE3);
        chk("beq_imm", e_imm, 32'hFFFFFFF8);
        chk("beq_br", 32'(e_branch), 1);
        chk("beq_f3", 32'(e_funct3), 0);
        chk("beq_rw", 32'(e_reg_write), 0);

        pc_cnt += 4;
        cyc(0, 0, 1, 32'h0000A103);
        pc_cnt += 4;
        cyc(0, 1, 1, 32'h001101B3);
        chk("fl_stall", 32'(obs_stall), 0);
        chk("fl_valid", 32'(e_valid), 0);

        pc_cnt += 4;
        cyc(0, 0, 1, 32'hFFFFFFFF);
        chk("ill_flag", 32'(e_illegal), 1);
        chk("ill_rw", 32'(e_reg_write), 0);
        chk("ill_mw", 32'(e_mem_write), 0);

        cur = gen_instr();
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 39) == 0);
            f = ($urandom_range(0, 9) == 0);
            v = m_stall || ($urandom_range(0, 7) != 0);
            cyc(r, f, v, cur);
            if (!m_stall) begin
                cur = gen_instr();
                pc_cnt += 4;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
